mips_wb_monitor: RTL and testbench

Synthesizable register-writeback monitor for the 5-stage MIPS datapath, replacing the fixed three-register, 24-cycle console print with a parametrised on-chip trace. It snoops the writeback port of `mips_datapath`, keeps shadow copies of `NUM_WATCH` selectable registers, and records every watched write with its cycle stamp into a readable trace FIFO. It sits beside `mips_datapath` at the top level, is driven by the same clock and reset, and is read out by a bench or debug port.

---
 rtl/mips_mon_pkg.sv | 38 +++
 rtl/mips_trace_fifo.sv | 58 +++++
 rtl/mips_wb_monitor.sv | 146 ++++++++++++++
 tb/tb_mips_wb_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mon_pkg.sv
// Shared types and helpers for the MIPS writeback monitor.
// State encodings, trace entry layout and width helpers.
package mips_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mon_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

   // Channel index width; a single channel still gets one bit.
   function automatic int chan_w(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

   // Entry layout, LSB first: data, addr, chan, cycle.
   function automatic int off_addr(input int dw);
      return dw;
   endfunction

   function automatic int off_chan(input int dw, input int aw);
      return dw + aw;
   endfunction

   function automatic int off_cyc(input int dw, input int aw,
                                  input int chw);
      return dw + aw + chw;
   endfunction

endpackage

// File: rtl/mips_trace_fifo.sv
// Show-ahead trace FIFO for the writeback monitor.
// Count-based full/empty; head reads as zero when empty.
module mips_trace_fifo
   import mips_mon_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage array, written on an accepted push.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap at DEPTH; occupancy tracks push minus pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mips_wb_monitor.sv
// Writeback monitor: shadows watched registers and traces
// every watched write with its cycle stamp into a FIFO.
module mips_wb_monitor
   import mips_mon_pkg::*;
#(
   parameter  int DATA_W     = 32,
   parameter  int REG_ADDR_W = 5,
   parameter  int NUM_WATCH  = 4,
   parameter  int DEPTH      = 16,
   parameter  int CYCLE_W    = 16,
   localparam int CH_W       = chan_w(NUM_WATCH)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wb_en,
   input  logic [REG_ADDR_W-1:0]         wb_addr,
   input  logic [DATA_W-1:0]             wb_data,
   input  logic [NUM_WATCH*REG_ADDR_W-1:0] watch_addr,
   input  logic [CYCLE_W-1:0]            max_cycles,
   input  logic                          arm,
   input  logic                          rd_en,
   output logic                          rd_valid,
   output logic [CYCLE_W-1:0]            rd_cycle,
   output logic [CH_W-1:0]               rd_chan,
   output logic [REG_ADDR_W-1:0]         rd_addr,
   output logic [DATA_W-1:0]             rd_data,
   output logic [NUM_WATCH*DATA_W-1:0]   watch_val,
   output logic [CYCLE_W-1:0]            cycle_count,
   output logic [1:0]                    state,
   output logic                          overflow,
   output logic                          done
);

   localparam int ENT_W = CYCLE_W + CH_W + REG_ADDR_W + DATA_W;
   localparam int O_AD  = off_addr(DATA_W);
   localparam int O_CH  = off_chan(DATA_W, REG_ADDR_W);
   localparam int O_CY  = off_cyc(DATA_W, REG_ADDR_W, CH_W);

   mon_state_e           state_q;
   mon_state_e           state_d;
   logic [CYCLE_W-1:0]   cnt_q;
   logic [DATA_W-1:0]    shadow_q [NUM_WATCH];
   logic [NUM_WATCH-1:0] match;
   logic [CH_W-1:0]      sel;
   logic                 capture;
   logic                 last;
   logic                 ovf_q;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [ENT_W-1:0]     fifo_din;
   logic [ENT_W-1:0]     fifo_dout;

   // Channel match with lowest-index priority; r0 never matches.
   always_comb begin
      match = '0;
      sel   = '0;
      for (int k = NUM_WATCH - 1; k >= 0; k--) begin
         if (wb_addr != '0 &&
             watch_addr[k*REG_ADDR_W +: REG_ADDR_W] == wb_addr) begin
            match[k] = 1'b1;
            sel      = CH_W'(k);
         end
      end
   end

   assign last    = (max_cycles != '0) &&
                    (cnt_q == max_cycles - CYCLE_W'(1));
   assign capture = (state_q == ST_RUN) & wb_en & (|match) & ~arm;

   // Next-state logic; arm always (re)enters RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (arm) state_d = ST_RUN;
         ST_RUN:  if (!arm && last) state_d = ST_DONE;
         ST_DONE: if (arm) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // RUN cycle counter; saturates and freezes on the final cycle.
   always_ff @(posedge clk) begin
      if (reset || arm)
         cnt_q <= '0;
      else if (state_q == ST_RUN && !last && cnt_q != '1)
         cnt_q <= cnt_q + 1'b1;
   end

   // Shadow copies: every matching channel takes the write.
   always_ff @(posedge clk) begin
      if (reset || arm) begin
         for (int k = 0; k < NUM_WATCH; k++) shadow_q[k] <= '0;
      end else if (capture) begin
         for (int k = 0; k < NUM_WATCH; k++)
            if (match[k]) shadow_q[k] <= wb_data;
      end
   end

   // Sticky drop flag; a full FIFO accepts a push only with a pop.
   always_ff @(posedge clk) begin
      if (reset || arm)
         ovf_q <= 1'b0;
      else if (capture && fifo_full && !rd_en)
         ovf_q <= 1'b1;
   end

   assign fifo_din = {cnt_q, sel, wb_addr, wb_data};

   mips_trace_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (capture),
      .pop   (rd_en),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Pack shadows with the same layout as watch_addr.
   always_comb begin
      watch_val = '0;
      for (int k = 0; k < NUM_WATCH; k++)
         watch_val[k*DATA_W +: DATA_W] = shadow_q[k];
   end

   assign rd_valid    = ~fifo_empty;
   assign rd_data     = fifo_dout[DATA_W-1:0];
   assign rd_addr     = fifo_dout[O_AD +: REG_ADDR_W];
   assign rd_chan     = fifo_dout[O_CH +: CH_W];
   assign rd_cycle    = fifo_dout[O_CY +: CYCLE_W];
   assign cycle_count = cnt_q;
   assign state       = state_q;
   assign overflow    = ovf_q;
   assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_mips_wb_monitor.sv
// Bench for mips_wb_monitor: directed writes, expected trace
// entries queued and checked by an independent drain monitor.
module tb_mips_wb_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic [19:0] watch_addr = '0;
   logic [15:0] max_cycles = '0;
   logic        arm = 1'b0;
   logic        rd_en;
   logic        rd_valid;
   logic [15:0] rd_cycle;
   logic [1:0]  rd_chan;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [127:0] watch_val;
   logic [15:0] cycle_count;
   logic [1:0]  state;
   logic        overflow;
   logic        done;

   typedef struct {
      logic [15:0] cyc;
      logic [1:0]  chan;
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   logic drain = 1'b0;

   always #5 clk = ~clk;

   mips_wb_monitor dut (
      .clk         (clk),
      .reset       (reset),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .watch_addr  (watch_addr),
      .max_cycles  (max_cycles),
      .arm         (arm),
      .rd_en       (rd_en),
      .rd_valid    (rd_valid),
      .rd_cycle    (rd_cycle),
      .rd_chan     (rd_chan),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .watch_val   (watch_val),
      .cycle_count (cycle_count),
      .state       (state),
      .overflow    (overflow),
      .done        (done)
   );

   // Drain monitor: compares the head against the scoreboard.
   initial begin
      ent_t e;
      rd_en = 1'b0;
      forever begin
         @(negedge clk);
         rd_en = 1'b0;
         if (drain && rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL entry: unexpected cyc=%0d ch=%0d a=%0d d=%0h",
                        rd_cycle, rd_chan, rd_addr, rd_data);
            end else begin
               e = exp_q.pop_front();
               if (rd_cycle !== e.cyc || rd_chan !== e.chan ||
                   rd_addr !== e.addr || rd_data !== e.data) begin
                  bad++;
                  $display("FAIL entry: got cyc=%0d ch=%0d a=%0d d=%0h want cyc=%0d ch=%0d a=%0d d=%0h",
                           rd_cycle, rd_chan, rd_addr, rd_data,
                           e.cyc, e.chan, e.addr, e.data);
               end
            end
            rd_en = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic expect_ent(input logic [15:0] c, input logic [1:0] ch,
                             input logic [4:0] a, input logic [31:0] d);
      ent_t e;
      e.cyc = c;
      e.chan = ch;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wb_en = 1'b1;
      wb_addr = a;
      wb_data = d;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic drain_all(input string name);
      drain = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      drain = 1'b0;
      idle(2);
      chk({name, "_left"}, exp_q.size(), 0);
      chk({name, "_empty"}, rd_valid, 0);
   endtask

   function automatic logic [19:0] wpack(input logic [4:0] a0,
         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [31:0] sh(input int k);
      return watch_val[k*32 +: 32];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle(2);
      reset = 1'b0;
      chk("rst_state", state, 0);
      chk("rst_count", cycle_count, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_done", done, 0);
      chk("rst_watch", (watch_val == '0), 1);

      // basic trace
      watch_addr = wpack(5'd1, 5'd2, 5'd3, 5'd0);
      arm_pulse();
      chk("arm_state", state, 1);
      idle(2);
      wr(5'd1, 32'd5);
      expect_ent(16'd2, 2'd0, 5'd1, 32'd5);
      idle(1);
      wr(5'd3, 32'd7);
      expect_ent(16'd4, 2'd2, 5'd3, 32'd7);
      chk("t1_count", cycle_count, 5);
      chk("t1_sh0", sh(0), 5);
      chk("t1_sh1", sh(1), 0);
      chk("t1_sh2", sh(2), 7);
      drain_all("t1");

      // r0 never captured
      wr(5'd0, 32'd9);
      chk("r0_sh3", sh(3), 0);
      chk("r0_valid", rd_valid, 0);

      // two channels on one register
      watch_addr = wpack(5'd2, 5'd1, 5'd2, 5'd0);
      arm_pulse();
      wr(5'd2, 32'hAB);
      expect_ent(16'd0, 2'd0, 5'd2, 32'hAB);
      chk("dup_sh0", sh(0), 32'hAB);
      chk("dup_sh2", sh(2), 32'hAB);
      chk("dup_sh1", sh(1), 0);
      drain_all("dup");

      // overflow, then full with simultaneous push and pop
      watch_addr = wpack(5'd1, 5'd0, 5'd0, 5'd0);
      arm_pulse();
      for (int i = 0; i < 17; i++) begin
         wr(5'd1, 32'(100 + i));
         if (i < 16) expect_ent(16'(i), 2'd0, 5'd1, 32'(100 + i));
      end
      chk("ovf_set", overflow, 1);
      arm_pulse();
      chk("ovf_clr", overflow, 0);
      chk("ovf_kept", rd_valid, 1);
      wb_en = 1'b1;
      wb_addr = 5'd1;
      wb_data = 32'd200;
      drain = 1'b1;
      expect_ent(16'd0, 2'd0, 5'd1, 32'd200);
      tick();
      wb_en = 1'b0;
      drain = 1'b0;
      tick();
      chk("pp_ovf", overflow, 0);
      drain_all("ovf");

      // run length limit
      max_cycles = 16'd24;
      arm_pulse();
      idle(23);
      chk("lim_pre", cycle_count, 23);
      wr(5'd1, 32'h55);
      expect_ent(16'd23, 2'd0, 5'd1, 32'h55);
      chk("lim_done", done, 1);
      chk("lim_state", state, 2);
      chk("lim_count", cycle_count, 23);
      wr(5'd1, 32'h66);
      idle(2);
      chk("lim_frozen", cycle_count, 23);
      chk("lim_sh0", sh(0), 32'h55);
      max_cycles = 16'd0;
      arm_pulse();
      chk("rearm_count", cycle_count, 0);
      chk("rearm_state", state, 1);
      chk("rearm_kept", rd_valid, 1);
      chk("rearm_sh0", sh(0), 0);
      drain_all("lim");

      // reset mid-run overrides arm
      arm_pulse();
      wr(5'd1, 32'd1);
      wr(5'd1, 32'd2);
      wr(5'd1, 32'd3);
      chk("mid_valid", rd_valid, 1);
      reset = 1'b1;
      arm = 1'b1;
      tick();
      reset = 1'b0;
      arm = 1'b0;
      chk("mid_state", state, 0);
      chk("mid_valid0", rd_valid, 0);
      chk("mid_data", rd_data, 0);
      chk("mid_count", cycle_count, 0);
      chk("mid_ovf", overflow, 0);
      chk("mid_watch", (watch_val == '0), 1);

      chk("end_queue", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
